// File: rtl/taxi_pkg.sv
// Shared types for the taxi meter: trip state, meter word and the saturating add
// used by both the trip meter and the fare calculator.
package taxi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIRED = 2'd1,
        SLOW  = 2'd2,
        DONE  = 2'd3
    } trip_state_e;

    typedef logic [31:0] meter_word_t;

    localparam meter_word_t MAX_WORD = 32'hFFFF_FFFF;

    // Add two meter words, pinning the result at MAX_WORD instead of wrapping.
    function automatic meter_word_t sat_add(input meter_word_t a, input meter_word_t b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            sat_add = MAX_WORD;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/taxi_pulse_sync.sv
// Two-flop synchroniser for the raw wheel sensor plus a rising-edge detector
// whose one-cycle pulse output is registered.
module taxi_pulse_sync (
    input  logic clk,
    input  logic stop_state,
    input  logic async_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic pulse_q, pulse_d;

    // Next-state for the synchroniser chain and edge detector
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        pulse_d = sync2_q & ~sync3_q;
    end

    // Synchroniser and pulse flops, cleared by stop_state
    always_ff @(posedge clk) begin
        if (stop_state) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/taxi_trip_meter.sv
// Trip measurement front end: accumulates distance from wheel pulses and
// low-speed waiting units, and tracks the trip state for the display.
module taxi_trip_meter
    import taxi_pkg::*;
#(
    parameter int unsigned     METERS_PER_PULSE = 10,
    parameter int unsigned     SLOW_WINDOW      = 50_000_000,
    parameter longint unsigned LOW_UNIT_CYCLES  = 64'd3_000_000_000
) (
    input  logic        clk,
    input  logic        stop_state,
    input  logic        wheel_in,
    input  logic        start_trip,
    input  logic        end_trip,
    output logic [31:0] distance,
    output logic [31:0] low_time,
    output logic        trip_active,
    output logic        slow
);

    localparam int GAP_W  = (SLOW_WINDOW > 32'd1) ? $clog2(SLOW_WINDOW) : 1;
    localparam int UNIT_W = (LOW_UNIT_CYCLES > 64'd1) ? $clog2(LOW_UNIT_CYCLES) : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SLOW_WINDOW - 32'd1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1'b1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(LOW_UNIT_CYCLES - 64'd1);
    localparam logic [UNIT_W-1:0] UNIT_ONE  = UNIT_W'(1'b1);
    localparam meter_word_t       STEP      = meter_word_t'(METERS_PER_PULSE);

    logic pulse_s;

    trip_state_e      state_q, state_d;
    meter_word_t      distance_q, distance_d;
    meter_word_t      low_time_q, low_time_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic             trip_active_q, trip_active_d;
    logic             slow_q, slow_d;

    taxi_pulse_sync u_wheel_sync (
        .clk        (clk),
        .stop_state (stop_state),
        .async_in   (wheel_in),
        .pulse      (pulse_s)
    );

    // Trip state machine and accumulators; start beats end beats pulse
    always_comb begin
        state_d    = state_q;
        distance_d = distance_q;
        low_time_d = low_time_q;
        gap_d      = gap_q;
        unit_d     = unit_q;

        if (start_trip) begin
            state_d    = HIRED;
            distance_d = 32'd0;
            low_time_d = 32'd0;
            gap_d      = '0;
            unit_d     = '0;
        end else if (end_trip && ((state_q == HIRED) || (state_q == SLOW))) begin
            state_d = DONE;
        end else begin
            case (state_q)
                HIRED: begin
                    if (pulse_s) begin
                        distance_d = sat_add(distance_q, STEP);
                        gap_d      = '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_d = SLOW;
                        unit_d  = '0;
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
                SLOW: begin
                    // A unit completing on the same edge as a pulse still counts
                    if (unit_q == UNIT_LAST) begin
                        unit_d     = '0;
                        low_time_d = sat_add(low_time_q, 32'd1);
                    end else begin
                        unit_d = unit_q + UNIT_ONE;
                    end
                    if (pulse_s) begin
                        distance_d = sat_add(distance_q, STEP);
                        gap_d      = '0;
                        unit_d     = '0;
                        state_d    = HIRED;
                    end else begin
                        gap_d = GAP_LAST;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        trip_active_d = (state_d == HIRED) || (state_d == SLOW);
        slow_d        = (state_d == SLOW);
    end

    // State, accumulator and output flops with synchronous stop_state clear
    always_ff @(posedge clk) begin
        if (stop_state) begin
            state_q       <= IDLE;
            distance_q    <= 32'd0;
            low_time_q    <= 32'd0;
            gap_q         <= '0;
            unit_q        <= '0;
            trip_active_q <= 1'b0;
            slow_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            distance_q    <= distance_d;
            low_time_q    <= low_time_d;
            gap_q         <= gap_d;
            unit_q        <= unit_d;
            trip_active_q <= trip_active_d;
            slow_q        <= slow_d;
        end
    end

    assign distance    = distance_q;
    assign low_time    = low_time_q;
    assign trip_active = trip_active_q;
    assign slow        = slow_q;

endmodule
